// File: rtl/matrix_stream_decoder.sv
// Turns the UART byte stream into a DIM x DIM complex matrix. After the command
// byte, each little-endian signed element goes out through a valid/accept register.
module matrix_stream_decoder #(
   parameter int         DIM            = 2,
   parameter int         ELEM_WIDTH     = 37,
   parameter logic [7:0] CMD_BYTE       = 8'h4D,
   parameter int         TIMEOUT_CYCLES = 0,
   localparam int        BYTES          = (ELEM_WIDTH + 7) / 8,
   localparam int        IW             = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   rx_byte,
   input  logic                         rx_ready,
   output logic signed [ELEM_WIDTH-1:0] elem_data,
   output logic [IW-1:0]                elem_row,
   output logic [IW-1:0]                elem_col,
   output logic                         elem_imag,
   output logic                         elem_valid,
   input  logic                         elem_accept,
   output logic                         matrix_done,
   output logic                         busy,
   output logic                         overrun_err,
   output logic                         range_err,
   output logic                         timeout_err,
   input  logic                         err_clear
);

   localparam int AW  = 8 * BYTES;
   localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [AW-1:0]   asm_r;
   logic [AW-1:0]   shift_s;
   logic [BCW-1:0]  byte_cnt_r;
   logic [TCW-1:0]  tmo_cnt_r;
   logic [IW-1:0]   row_r;
   logic [IW-1:0]   col_r;
   logic            imag_r;
   logic            last_s;
   logic            take_s;
   logic            load_s;
   logic            overrun_s;
   logic            range_s;
   logic            timeout_s;
   logic            done_s;

   // Padding bits above the element must all repeat its sign bit.
   function automatic logic range_bad(input logic [AW-1:0] word);
      logic bad;
      bad = 1'b0;
      for (int i = ELEM_WIDTH; i < AW; i++) begin
         bad = bad | (word[i] ^ word[ELEM_WIDTH-1]);
      end
      return bad;
   endfunction

   assign shift_s = AW'({rx_byte, asm_r} >> 4'd8);
   assign last_s  = imag_r & (row_r == IW'(DIM - 1)) & (col_r == IW'(DIM - 1));
   assign take_s  = elem_valid & elem_accept;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode and per-cycle event strobes.
   always_comb begin
      next_state_s = state_r;
      load_s       = 1'b0;
      overrun_s    = 1'b0;
      range_s      = 1'b0;
      timeout_s    = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (rx_ready && (rx_byte == CMD_BYTE)) begin
               next_state_s = COLLECT;
            end else begin
               next_state_s = IDLE;
            end
         end
         COLLECT: begin
            if (rx_ready && (byte_cnt_r == BCW'(BYTES - 1))) begin
               range_s = range_bad(shift_s);
               // An accept in this same cycle frees the register for the new element.
               if (!elem_valid || elem_accept) begin
                  load_s = 1'b1;
                  if (last_s) begin
                     next_state_s = DRAIN;
                  end else begin
                     next_state_s = COLLECT;
                  end
               end else begin
                  overrun_s    = 1'b1;
                  next_state_s = IDLE;
               end
            end else if (!rx_ready && (TIMEOUT_CYCLES > 0) &&
                         (tmo_cnt_r == TCW'(TIMEOUT_CYCLES - 1))) begin
               timeout_s    = 1'b1;
               next_state_s = IDLE;
            end else begin
               next_state_s = COLLECT;
            end
         end
         DRAIN: begin
            if (take_s) begin
               done_s       = 1'b1;
               next_state_s = IDLE;
            end else begin
               next_state_s = DRAIN;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Byte assembly, idle timer and element tag counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         asm_r      <= '0;
         byte_cnt_r <= '0;
         tmo_cnt_r  <= '0;
         row_r      <= '0;
         col_r      <= '0;
         imag_r     <= 1'b0;
      end else begin
         if (state_r == COLLECT) begin
            if (rx_ready) begin
               asm_r     <= shift_s;
               tmo_cnt_r <= '0;
               if (byte_cnt_r == BCW'(BYTES - 1)) begin
                  byte_cnt_r <= '0;
               end else begin
                  byte_cnt_r <= byte_cnt_r + BCW'(1);
               end
            end else begin
               tmo_cnt_r <= tmo_cnt_r + TCW'(1);
            end
         end else begin
            asm_r      <= '0;
            byte_cnt_r <= '0;
            tmo_cnt_r  <= '0;
         end

         if (state_r == IDLE) begin
            row_r  <= '0;
            col_r  <= '0;
            imag_r <= 1'b0;
         end else if (load_s) begin
            if (!imag_r) begin
               imag_r <= 1'b1;
            end else if (col_r == IW'(DIM - 1)) begin
               imag_r <= 1'b0;
               col_r  <= '0;
               row_r  <= row_r + IW'(1);
            end else begin
               imag_r <= 1'b0;
               col_r  <= col_r + IW'(1);
            end
         end else begin
            imag_r <= imag_r;
         end
      end
   end

   // Output register, status strobes and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         elem_data   <= '0;
         elem_row    <= '0;
         elem_col    <= '0;
         elem_imag   <= 1'b0;
         elem_valid  <= 1'b0;
         matrix_done <= 1'b0;
         busy        <= 1'b0;
         overrun_err <= 1'b0;
         range_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (load_s) begin
            elem_data  <= shift_s[ELEM_WIDTH-1:0];
            elem_row   <= row_r;
            elem_col   <= col_r;
            elem_imag  <= imag_r;
            elem_valid <= 1'b1;
         end else if (take_s) begin
            elem_valid <= 1'b0;
         end else begin
            elem_valid <= elem_valid;
         end
         matrix_done <= done_s;
         busy        <= (next_state_s != IDLE);
         overrun_err <= overrun_s | (overrun_err & ~err_clear);
         range_err   <= range_s   | (range_err   & ~err_clear);
         timeout_err <= timeout_s | (timeout_err & ~err_clear);
      end
   end

endmodule

// File: tb/tb_matrix_stream_decoder.sv
// Directed bench for matrix_stream_decoder: an element-queue model (index arithmetic
// for tags, masking for truncation) checked every cycle, plus literal spot checks.
module tb_matrix_stream_decoder;

   localparam int DIM_A = 2;
   localparam int EW_A  = 37;
   localparam int DIM_B = 3;
   localparam int EW_B  = 16;

   typedef struct {
      logic [63:0] data;
      int          row;
      int          col;
      int          imag;
      bit          last;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic [7:0]      rx_byte_a, rx_byte_b;
   logic            rx_ready_a, rx_ready_b, accept_a, accept_b, err_clear_a, err_clear_b;
   logic [EW_A-1:0] elem_data_a;
   logic [EW_B-1:0] elem_data_b;
   logic [0:0]      elem_row_a, elem_col_a;
   logic [1:0]      elem_row_b, elem_col_b;
   logic            elem_imag_a, elem_valid_a, matrix_done_a, busy_a, overrun_a, range_a, timeout_a;
   logic            elem_imag_b, elem_valid_b, matrix_done_b, busy_b, overrun_b, range_b, timeout_b;

   matrix_stream_decoder #(.DIM(DIM_A), .ELEM_WIDTH(EW_A), .CMD_BYTE(8'h4D), .TIMEOUT_CYCLES(20)) u_dut_a (
      .clk(clk), .reset(reset), .rx_byte(rx_byte_a), .rx_ready(rx_ready_a),
      .elem_data(elem_data_a), .elem_row(elem_row_a), .elem_col(elem_col_a),
      .elem_imag(elem_imag_a), .elem_valid(elem_valid_a), .elem_accept(accept_a),
      .matrix_done(matrix_done_a), .busy(busy_a), .overrun_err(overrun_a),
      .range_err(range_a), .timeout_err(timeout_a), .err_clear(err_clear_a)
   );

   matrix_stream_decoder #(.DIM(DIM_B), .ELEM_WIDTH(EW_B), .CMD_BYTE(8'h4D), .TIMEOUT_CYCLES(0)) u_dut_b (
      .clk(clk), .reset(reset), .rx_byte(rx_byte_b), .rx_ready(rx_ready_b),
      .elem_data(elem_data_b), .elem_row(elem_row_b), .elem_col(elem_col_b),
      .elem_imag(elem_imag_b), .elem_valid(elem_valid_b), .elem_accept(accept_b),
      .matrix_done(matrix_done_b), .busy(busy_b), .overrun_err(overrun_b),
      .range_err(range_b), .timeout_err(timeout_b), .err_clear(err_clear_b)
   );

   int   n_cmp = 0;
   int   n_fail = 0;
   int   done_cnt_a = 0;
   int   done_cnt_b = 0;
   bit   exp_done_a = 1'b0;
   bit   exp_done_b = 1'b0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   logic [39:0] mat_a [8];
   logic [15:0] mat_b [18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Element k of a load: tags by row-major index arithmetic, data truncated to ew bits.
   function automatic exp_t model_elem(input int dim, input int ew, input logic [63:0] raw, input int k);
      exp_t e;
      int   idx;
      idx    = k / 2;
      e.data = raw & ((64'd1 << ew) - 64'd1);
      e.row  = idx / dim;
      e.col  = idx % dim;
      e.imag = k % 2;
      e.last = (k == 2 * dim * dim - 1);
      return e;
   endfunction

   // Per-cycle compare: matrix_done against the model, and each accepted element against the queue.
   always @(negedge clk) begin
      if (!reset) begin
         exp_done_a = 1'b0;
         exp_done_b = 1'b0;
      end else begin
         check("matrix_done_a", 64'(matrix_done_a), 64'(exp_done_a));
         check("matrix_done_b", 64'(matrix_done_b), 64'(exp_done_b));
         if (matrix_done_a) done_cnt_a++;
         if (matrix_done_b) done_cnt_b++;
         exp_done_a = 1'b0;
         exp_done_b = 1'b0;
         if (elem_valid_a && accept_a) begin
            if (q_a.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL elem_a_unexpected: got element %0h, expected none", elem_data_a);
            end else begin
               ea = q_a.pop_front();
               check("elem_data_a", 64'(elem_data_a), ea.data);
               check("elem_row_a", 64'(elem_row_a), 64'(ea.row));
               check("elem_col_a", 64'(elem_col_a), 64'(ea.col));
               check("elem_imag_a", 64'(elem_imag_a), 64'(ea.imag));
               exp_done_a = ea.last;
            end
         end
         if (elem_valid_b && accept_b) begin
            if (q_b.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL elem_b_unexpected: got element %0h, expected none", elem_data_b);
            end else begin
               eb = q_b.pop_front();
               check("elem_data_b", 64'(elem_data_b), eb.data);
               check("elem_row_b", 64'(elem_row_b), 64'(eb.row));
               check("elem_col_b", 64'(elem_col_b), 64'(eb.col));
               check("elem_imag_b", 64'(elem_imag_b), 64'(eb.imag));
               exp_done_b = eb.last;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte_a(input logic [7:0] b);
      rx_byte_a  = b;
      rx_ready_a = 1'b1;
      tick();
      rx_ready_a = 1'b0;
      rx_byte_a  = 8'h00;
   endtask

   task automatic send_byte_b(input logic [7:0] b);
      rx_byte_b  = b;
      rx_ready_b = 1'b1;
      tick();
      rx_ready_b = 1'b0;
      rx_byte_b  = 8'h00;
   endtask

   task automatic send_raw_a(input logic [39:0] v);
      for (int i = 0; i < 5; i++) send_byte_a(v[8*i +: 8]);
   endtask

   task automatic stream_a(input int first, input int final_k);
      for (int k = first; k <= final_k; k++) begin
         q_a.push_back(model_elem(DIM_A, EW_A, 64'(mat_a[k]), k));
         send_raw_a(mat_a[k]);
      end
   endtask

   task automatic stream_b();
      for (int k = 0; k < 18; k++) begin
         q_b.push_back(model_elem(DIM_B, EW_B, 64'(mat_b[k]), k));
         send_byte_b(mat_b[k][7:0]);
         send_byte_b(mat_b[k][15:8]);
         if (k == 5) begin
            check("b_k5_row", 64'(elem_row_b), 64'd0);
            check("b_k5_col", 64'(elem_col_b), 64'd2);
            check("b_k5_imag", 64'(elem_imag_b), 64'd1);
         end
         if (k == 6) begin
            check("b_k6_row", 64'(elem_row_b), 64'd1);
            check("b_k6_col", 64'(elem_col_b), 64'd0);
            check("b_k6_data", 64'(elem_data_b), 64'h0000_0000_0000_F6E2);
         end
      end
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_data"}, 64'(elem_data_a), 64'd0);
      check({tag, "_row"}, 64'(elem_row_a), 64'd0);
      check({tag, "_col"}, 64'(elem_col_a), 64'd0);
      check({tag, "_imag"}, 64'(elem_imag_a), 64'd0);
      check({tag, "_valid"}, 64'(elem_valid_a), 64'd0);
      check({tag, "_done"}, 64'(matrix_done_a), 64'd0);
      check({tag, "_busy"}, 64'(busy_a), 64'd0);
      check({tag, "_errs"}, 64'({overrun_a, range_a, timeout_a}), 64'd0);
   endtask

   task automatic pulse_clear_a();
      err_clear_a = 1'b1;
      tick();
      err_clear_a = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      rx_byte_a = 8'h00; rx_ready_a = 1'b0; accept_a = 1'b1; err_clear_a = 1'b0;
      rx_byte_b = 8'h00; rx_ready_b = 1'b0; accept_b = 1'b1; err_clear_b = 1'b0;
      mat_a[0] = 40'd24296004000; mat_a[1] = 40'd0;
      mat_a[2] = 40'd24296004001; mat_a[3] = 40'd0;
      mat_a[4] = 40'd24296004002; mat_a[5] = 40'd0;
      mat_a[6] = 40'hFA_57D8665D; mat_a[7] = 40'd0;
      for (int k = 0; k < 18; k++) mat_b[k] = 16'(k * 1111 - 9000);

      repeat (3) @(posedge clk);
      #1;
      check_reset_a("rst0");
      check("rst0_b_valid", 64'({elem_valid_b, busy_b, elem_data_b}), 64'd0);
      reset = 1'b1;
      tick();

      // Full load with accept held high.
      check("t1_busy_before", 64'(busy_a), 64'd0);
      send_byte_a(8'h4D);
      check("t1_busy_after_cmd", 64'(busy_a), 64'd1);
      stream_a(0, 0);
      check("t1_valid_lat1", 64'(elem_valid_a), 64'd1);
      check("t1_elem0", 64'(elem_data_a), 64'd24296004000);
      stream_a(1, 6);
      check("t1_elem6_neg", 64'(elem_data_a), 64'h0000_001A_57D8_665D);
      stream_a(7, 7);
      repeat (3) tick();
      check("t1_done_count", 64'(done_cnt_a), 64'd1);
      check("t1_busy_end", 64'(busy_a), 64'd0);
      check("t1_errs", 64'({overrun_a, range_a, timeout_a}), 64'd0);
      check("t1_queue_empty", 64'(q_a.size()), 64'd0);

      // Overrun: consumer stalls after the first element.
      accept_a = 1'b0;
      send_byte_a(8'h4D);
      stream_a(0, 0);
      send_raw_a(mat_a[1]);
      check("t2_overrun", 64'(overrun_a), 64'd1);
      check("t2_busy", 64'(busy_a), 64'd0);
      check("t2_valid_kept", 64'(elem_valid_a), 64'd1);
      check("t2_data_kept", 64'(elem_data_a), 64'd24296004000);
      check("t2_imag_kept", 64'(elem_imag_a), 64'd0);
      accept_a = 1'b1;
      tick();
      check("t2_valid_after_take", 64'(elem_valid_a), 64'd0);
      check("t2_queue_empty", 64'(q_a.size()), 64'd0);
      check("t2_no_done", 64'(done_cnt_a), 64'd1);
      pulse_clear_a();
      check("t2_cleared", 64'(overrun_a), 64'd0);

      // Range error on padding bits; the load carries on.
      mat_a[0] = 40'h15_A82799A0;
      send_byte_a(8'h4D);
      stream_a(0, 0);
      check("t3_range", 64'(range_a), 64'd1);
      check("t3_trunc", 64'(elem_data_a), 64'h0000_0015_A827_99A0);
      stream_a(1, 7);
      repeat (3) tick();
      check("t3_done_count", 64'(done_cnt_a), 64'd2);
      check("t3_overrun", 64'(overrun_a), 64'd0);
      mat_a[0] = 40'd24296004000;
      pulse_clear_a();
      check("t3_cleared", 64'(range_a), 64'd0);

      // Inter-byte timeout of 20 cycles.
      send_byte_a(8'h4D);
      send_byte_a(8'h11);
      send_byte_a(8'h22);
      send_byte_a(8'h33);
      repeat (19) tick();
      check("t4_no_timeout_19", 64'(timeout_a), 64'd0);
      check("t4_busy_19", 64'(busy_a), 64'd1);
      tick();
      check("t4_timeout_20", 64'(timeout_a), 64'd1);
      check("t4_busy_20", 64'(busy_a), 64'd0);
      send_byte_a(8'h00);
      check("t4_idle_ignores", 64'(busy_a), 64'd0);
      pulse_clear_a();
      check("t4_cleared", 64'(timeout_a), 64'd0);

      // Non-command byte, 0x4D as data, then reset mid-load.
      send_byte_a(8'h4C);
      check("t5_L_ignored", 64'(busy_a), 64'd0);
      send_byte_a(8'h4D);
      check("t5_busy", 64'(busy_a), 64'd1);
      q_a.push_back(model_elem(DIM_A, EW_A, 64'h4D, 0));
      send_raw_a(40'h00_0000_004D);
      check("t5_cmd_as_data", 64'(elem_data_a), 64'd77);
      send_byte_a(8'h4D);
      send_byte_a(8'h4D);
      reset = 1'b0;
      #1;
      check_reset_a("t5_rst");
      q_a.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      send_byte_a(8'h4D);
      stream_a(0, 7);
      repeat (3) tick();
      check("t5_done_count", 64'(done_cnt_a), 64'd3);
      check("t5_queue_empty", 64'(q_a.size()), 64'd0);

      // DIM=3, 16-bit elements on the second instance.
      send_byte_b(8'h4D);
      stream_b();
      repeat (3) tick();
      check("t6_done_count", 64'(done_cnt_b), 64'd1);
      check("t6_busy", 64'(busy_b), 64'd0);
      check("t6_errs", 64'({overrun_b, range_b, timeout_b}), 64'd0);
      check("t6_queue_empty", 64'(q_b.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
